// File: rtl/multicycle_control.sv
// Central sequencer for a multi-cycle RV32I datapath: shares one memory port between
// fetch and load/store, drives every datapath enable/select, and traps on faults.
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r_en,
    input  logic       i_en,
    input  logic       im_en,
    input  logic       s_en,
    input  logic       b_en,
    input  logic       jal_en,
    input  logic       jalr_en,
    input  logic       lui_en,
    input  logic       auipc_en,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic       rd_we,
    output logic [1:0] rd_sel,
    output logic       instret,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_t;

    // The trap fires on the stall cycle that would bring the count up to the limit.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] cnt_q, cnt_d;

    logic       req_c, we_c, addr_c, ir_c, mdr_c, pcwe_c, b_c, rdwe_c, ret_c;
    logic [1:0] pcsel_c, a_c, rdsel_c;
    logic [8:0] flags;
    logic       one_hot;

    assign flags   = {auipc_en, lui_en, jalr_en, jal_en, b_en, s_en, im_en, i_en, r_en};
    assign one_hot = (flags != 9'd0) && ((flags & (flags - 9'd1)) == 9'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        cnt_d   = 8'd0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = 1'b0;
        ir_c    = 1'b0;
        mdr_c   = 1'b0;
        pcwe_c  = 1'b0;
        pcsel_c = 2'd0;
        a_c     = 2'd0;
        b_c     = 1'b0;
        rdwe_c  = 1'b0;
        rdsel_c = 2'd0;
        ret_c   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_c    = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == LIMIT) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (one_hot) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd1;
                end
            end
            S_EXECUTE: begin
                if (r_en) begin
                    state_d = S_WB;
                end else if (i_en) begin
                    b_c     = 1'b1;
                    state_d = S_WB;
                end else if (lui_en) begin
                    a_c     = 2'd2;
                    b_c     = 1'b1;
                    state_d = S_WB;
                end else if (auipc_en) begin
                    a_c     = 2'd1;
                    b_c     = 1'b1;
                    state_d = S_WB;
                end else if (im_en || s_en) begin
                    b_c     = 1'b1;
                    state_d = S_MEM;
                end else if (b_en) begin
                    pcwe_c  = 1'b1;
                    pcsel_c = branch_taken ? 2'd1 : 2'd0;
                    ret_c   = 1'b1;
                    state_d = S_FETCH;
                end else if (jal_en) begin
                    pcwe_c  = 1'b1;
                    pcsel_c = 2'd1;
                    rdwe_c  = 1'b1;
                    rdsel_c = 2'd2;
                    ret_c   = 1'b1;
                    state_d = S_FETCH;
                end else if (jalr_en) begin
                    b_c     = 1'b1;
                    pcwe_c  = 1'b1;
                    pcsel_c = 2'd2;
                    rdwe_c  = 1'b1;
                    rdsel_c = 2'd2;
                    ret_c   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd1;
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                addr_c = 1'b1;
                we_c   = s_en;
                b_c    = 1'b1;
                if (mem_ready) begin
                    if (s_en) begin
                        pcwe_c  = 1'b1;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_c   = 1'b1;
                        state_d = S_WB;
                    end
                end else if (cnt_q == LIMIT) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                rdwe_c  = 1'b1;
                rdsel_c = im_en ? 2'd1 : 2'd0;
                pcwe_c  = 1'b1;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Every output is held low during reset so nothing is requested or written.
    assign mem_req      = req_c & ~rst;
    assign mem_we       = we_c & ~rst;
    assign mem_addr_sel = addr_c & ~rst;
    assign ir_we        = ir_c & ~rst;
    assign mdr_we       = mdr_c & ~rst;
    assign pc_we        = pcwe_c & ~rst;
    assign pc_sel       = rst ? 2'd0 : pcsel_c;
    assign alu_a_sel    = rst ? 2'd0 : a_c;
    assign alu_b_sel    = b_c & ~rst;
    assign rd_we        = rdwe_c & ~rst;
    assign rd_sel       = rst ? 2'd0 : rdsel_c;
    assign instret      = ret_c & ~rst;
    assign trap         = trap_q & ~rst;
    assign trap_cause   = rst ? 2'd0 : cause_q;
    assign state        = rst ? 3'd0 : state_q;

endmodule
